corelet_ctrl: RTL and testbench

CORELET_CTRL -- requirements
Module: corelet_ctrl

---
 rtl/corelet_pkg.sv | 24 ++
 rtl/corelet_ctrl_l0_loader.sv | 78 +++++++
 rtl/corelet_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_corelet_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/corelet_pkg.sv
// Shared types and constants for the corelet job controller.
package corelet_pkg;

  // Job sequencing states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WLOAD = 3'd1,
    KLOAD = 3'd2,
    ALOAD = 3'd3,
    EXEC  = 3'd4,
    DRAIN = 3'd5,
    DONE  = 3'd6
  } state_t;

  // Array instruction encodings {execute, kernel load}
  localparam logic [1:0] INST_IDLE  = 2'b00;
  localparam logic [1:0] INST_KLOAD = 2'b01;
  localparam logic [1:0] INST_EXEC  = 2'b10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/corelet_ctrl_l0_loader.sv
// Streams a block of SRAM words into L0: one read per cycle from base upward,
// each read written to L0 one cycle later, issue paused while L0 is full.
module l0_loader #(
  parameter int ADDR_BW = 11,
  parameter int CNT_W   = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_BW-1:0] base,
  input  logic [CNT_W-1:0]   count,
  input  logic               l0_full,
  output logic               sram_rd,
  output logic [ADDR_BW-1:0] sram_addr,
  output logic               l0_wr,
  output logic               finished
);

  logic               r_active;
  logic [ADDR_BW-1:0] r_base;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_issued;
  logic [CNT_W-1:0]   r_wcnt;
  logic               r_sram_rd;
  logic [ADDR_BW-1:0] r_sram_addr;
  logic               r_l0_wr;
  logic               w_can_issue;
  logic               w_finished;

  assign w_can_issue = r_active && (r_issued < r_count) && !l0_full;
  // The last L0 write is visible this cycle; the caller advances on this edge.
  assign w_finished  = r_active && r_l0_wr && (r_wcnt == (r_count - CNT_W'(1)));

  assign sram_rd   = r_sram_rd;
  assign sram_addr = r_sram_addr;
  assign l0_wr     = r_l0_wr;
  assign finished  = w_finished;

  // Issue reads, follow each with an L0 write, and count completed writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active    <= 1'b0;
      r_base      <= '0;
      r_count     <= '0;
      r_issued    <= '0;
      r_wcnt      <= '0;
      r_sram_rd   <= 1'b0;
      r_sram_addr <= '0;
      r_l0_wr     <= 1'b0;
    end else begin
      // A read in flight is always written, even if L0 just went full.
      r_l0_wr <= r_sram_rd;
      if (start) begin
        r_active <= 1'b1;
        r_base   <= base;
        r_count  <= count;
        r_wcnt   <= '0;
        if (!l0_full && (count != '0)) begin
          r_sram_rd   <= 1'b1;
          r_sram_addr <= base;
          r_issued    <= CNT_W'(1);
        end else begin
          r_sram_rd <= 1'b0;
          r_issued  <= '0;
        end
      end else begin
        r_sram_rd <= w_can_issue;
        if (w_can_issue) begin
          r_sram_addr <= r_base + ADDR_BW'(r_issued);
          r_issued    <= r_issued + CNT_W'(1);
        end
        if (r_active && r_l0_wr) r_wcnt <= r_wcnt + CNT_W'(1);
        if (w_finished) r_active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/corelet_ctrl.sv
// Corelet job controller: loads kernels and activations through L0, runs the
// array, and drains OFIFO results into psum memory. All outputs are registered.
module corelet_ctrl
  import corelet_pkg::*;
#(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int ADDR_BW = 11,
  parameter int LEN_BW  = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LEN_BW-1:0]  len,
  input  logic [ADDR_BW-1:0] kbase,
  input  logic [ADDR_BW-1:0] abase,
  input  logic [ADDR_BW-1:0] pbase,
  input  logic               relu_en,
  input  logic               acc_en,
  output logic               sram_rd,
  output logic [ADDR_BW-1:0] sram_addr,
  output logic               l0_wr,
  output logic               l0_rd,
  input  logic               l0_full,
  input  logic               l0_ready,
  output logic [1:0]         inst,
  output logic               ofifo_rd,
  input  logic               ofifo_valid,
  input  logic               ofifo_full,
  output logic               psum_wr,
  output logic [ADDR_BW-1:0] psum_addr,
  output logic               accumulate,
  output logic               relu,
  output logic               busy,
  output logic               done
);

  // Wide enough for the KLOAD read+propagation count and any job length.
  localparam int CNT_W = $clog2(max_int(col + row, 2 ** LEN_BW)) + 1;

  state_t             r_state;
  state_t             w_next;
  logic [LEN_BW-1:0]  r_len;
  logic [ADDR_BW-1:0] r_abase;
  logic [ADDR_BW-1:0] r_pbase;
  logic               r_relu_en;
  logic               r_acc_en;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_rdcnt;
  logic [CNT_W-1:0]   r_ocnt;
  logic [CNT_W-1:0]   r_pcnt;
  logic               r_l0_rd;
  logic [1:0]         r_inst;
  logic               r_ofifo_rd;
  logic               r_psum_wr;
  logic [ADDR_BW-1:0] r_psum_addr;
  logic               r_accumulate;
  logic               r_relu;
  logic               r_busy;
  logic               r_done;

  logic               w_ld_start;
  logic [ADDR_BW-1:0] w_ld_base;
  logic [CNT_W-1:0]   w_ld_count;
  logic               w_ld_sram_rd;
  logic [ADDR_BW-1:0] w_ld_sram_addr;
  logic               w_ld_l0_wr;
  logic               w_ld_finished;
  logic [CNT_W-1:0]   w_len_c;
  logic               w_kl_rd;
  logic               w_ex_rd;
  logic               w_of_rd;
  logic               w_relu_src;
  logic               w_acc_src;

  assign w_len_c    = CNT_W'(r_len);
  assign w_kl_rd    = (r_state == KLOAD) && (r_cnt < CNT_W'(col)) && l0_ready;
  assign w_ex_rd    = (r_state == EXEC) && (r_rdcnt < w_len_c) && l0_ready && !ofifo_full;
  assign w_of_rd    = ((r_state == EXEC) || (r_state == DRAIN)) && ofifo_valid;
  // Config is taken straight from the ports on the start edge itself.
  assign w_relu_src = (r_state == IDLE) ? relu_en : r_relu_en;
  assign w_acc_src  = (r_state == IDLE) ? acc_en  : r_acc_en;

  l0_loader #(
    .ADDR_BW (ADDR_BW),
    .CNT_W   (CNT_W)
  ) u_l0_loader (
    .clk       (clk),
    .reset     (reset),
    .start     (w_ld_start),
    .base      (w_ld_base),
    .count     (w_ld_count),
    .l0_full   (l0_full),
    .sram_rd   (w_ld_sram_rd),
    .sram_addr (w_ld_sram_addr),
    .l0_wr     (w_ld_l0_wr),
    .finished  (w_ld_finished)
  );

  assign sram_rd    = w_ld_sram_rd;
  assign sram_addr  = w_ld_sram_addr;
  assign l0_wr      = w_ld_l0_wr;
  assign l0_rd      = r_l0_rd;
  assign inst       = r_inst;
  assign ofifo_rd   = r_ofifo_rd;
  assign psum_wr    = r_psum_wr;
  assign psum_addr  = r_psum_addr;
  assign accumulate = r_accumulate;
  assign relu       = r_relu;
  assign busy       = r_busy;
  assign done       = r_done;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and loader launch (kernels from WLOAD, activations from ALOAD).
  always_comb begin
    w_next     = r_state;
    w_ld_start = 1'b0;
    w_ld_base  = kbase;
    w_ld_count = CNT_W'(col);
    case (r_state)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            w_next     = WLOAD;
            w_ld_start = 1'b1;
          end else begin
            w_next = DONE;
          end
        end
      end
      WLOAD: if (w_ld_finished) w_next = KLOAD;
      KLOAD: begin
        // col reads followed by row propagation cycles
        if (r_cnt == CNT_W'(col + row - 1)) begin
          w_next     = ALOAD;
          w_ld_start = 1'b1;
          w_ld_base  = r_abase;
          w_ld_count = w_len_c;
        end
      end
      ALOAD: if (w_ld_finished) w_next = EXEC;
      EXEC:  if (w_ex_rd && (r_rdcnt == (w_len_c - CNT_W'(1)))) w_next = DRAIN;
      DRAIN: if (r_pcnt == w_len_c) w_next = DONE;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Job latches, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len        <= '0;
      r_abase      <= '0;
      r_pbase      <= '0;
      r_relu_en    <= 1'b0;
      r_acc_en     <= 1'b0;
      r_cnt        <= '0;
      r_rdcnt      <= '0;
      r_ocnt       <= '0;
      r_pcnt       <= '0;
      r_l0_rd      <= 1'b0;
      r_inst       <= INST_IDLE;
      r_ofifo_rd   <= 1'b0;
      r_psum_wr    <= 1'b0;
      r_psum_addr  <= '0;
      r_accumulate <= 1'b0;
      r_relu       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      if ((r_state == IDLE) && start) begin
        r_len     <= len;
        r_abase   <= abase;
        r_pbase   <= pbase;
        r_relu_en <= relu_en;
        r_acc_en  <= acc_en;
        r_cnt     <= '0;
        r_rdcnt   <= '0;
        r_ocnt    <= '0;
        r_pcnt    <= '0;
      end else begin
        if (w_kl_rd || ((r_state == KLOAD) && (r_cnt >= CNT_W'(col))))
          r_cnt <= r_cnt + CNT_W'(1);
        if (w_ex_rd) r_rdcnt <= r_rdcnt + CNT_W'(1);
        if (w_of_rd) r_ocnt <= r_ocnt + CNT_W'(1);
        if (r_ofifo_rd) r_pcnt <= r_pcnt + CNT_W'(1);
      end
      // psum write trails its OFIFO read by one cycle; address wraps naturally.
      if (r_ofifo_rd) r_psum_addr <= r_pbase + ADDR_BW'(r_pcnt);
      r_psum_wr  <= r_ofifo_rd;
      r_ofifo_rd <= w_of_rd;
      r_l0_rd    <= w_kl_rd || w_ex_rd;
      case (w_next)
        KLOAD:   r_inst <= INST_KLOAD;
        EXEC:    r_inst <= INST_EXEC;
        default: r_inst <= INST_IDLE;
      endcase
      r_busy       <= (w_next != IDLE);
      r_relu       <= (w_next != IDLE) && w_relu_src;
      r_accumulate <= (w_next != IDLE) && w_acc_src;
      r_done       <= (r_state == DONE);
    end
  end

endmodule

// File: tb/tb_corelet_ctrl.sv
// Directed bench for corelet_ctrl: nominal job, L0 and OFIFO backpressure,
// len=0, psum address wrap, ignored start, mid-job reset and config outputs.
module tb_corelet_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  len;
  logic [10:0] kbase, abase, pbase;
  logic        relu_en, acc_en;
  logic        sram_rd;
  logic [10:0] sram_addr;
  logic        l0_wr, l0_rd, l0_full, l0_ready;
  logic [1:0]  inst;
  logic        ofifo_rd, ofifo_valid, ofifo_full;
  logic        psum_wr;
  logic [10:0] psum_addr;
  logic        accumulate, relu, busy, done;

  corelet_ctrl #(.row(8), .col(8), .ADDR_BW(11), .LEN_BW(5)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .kbase(kbase), .abase(abase), .pbase(pbase),
    .relu_en(relu_en), .acc_en(acc_en),
    .sram_rd(sram_rd), .sram_addr(sram_addr), .l0_wr(l0_wr), .l0_rd(l0_rd),
    .l0_full(l0_full), .l0_ready(l0_ready), .inst(inst),
    .ofifo_rd(ofifo_rd), .ofifo_valid(ofifo_valid), .ofifo_full(ofifo_full),
    .psum_wr(psum_wr), .psum_addr(psum_addr), .accumulate(accumulate),
    .relu(relu), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Event monitor (sole writer of these counters and logs).
  int   n_srd = 0, n_l0wr = 0, n_l0rd = 0, n_ofrd = 0, n_pwr = 0, n_done = 0, n_kl = 0;
  int   v_stall = 0, v_hold = 0, v_ofull = 0, v_cfg = 0;
  int   srd_log [512];
  int   pwr_log [512];
  logic [10:0] last_addr = '0;
  logic [1:0]  mon_prev_inst = 2'b00;
  logic        exp_relu = 1'b0, exp_acc = 1'b0;
  logic        l0_full_q = 1'b0, ofull_q = 1'b0;

  always @(posedge clk) begin
    l0_full_q <= l0_full;
    ofull_q   <= ofifo_full;
  end

  always @(negedge clk) begin
    if (reset) begin
      if (l0_full_q && sram_rd) v_stall++;
      if (l0_full_q && (sram_addr != last_addr)) v_hold++;
      if (ofull_q && l0_rd && (mon_prev_inst == 2'b10)) v_ofull++;
      if (busy && ((relu !== exp_relu) || (accumulate !== exp_acc))) v_cfg++;
      if (!busy && (relu || accumulate)) v_cfg++;
      if (sram_rd) begin
        srd_log[n_srd & 511] = int'(sram_addr);
        last_addr = sram_addr;
        n_srd++;
      end
      if (l0_wr) n_l0wr++;
      if (l0_rd) n_l0rd++;
      if (ofifo_rd) n_ofrd++;
      if (psum_wr) begin
        pwr_log[n_pwr & 511] = int'(psum_addr);
        n_pwr++;
      end
      if (done) n_done++;
      if (inst == 2'b01) n_kl++;
    end
    mon_prev_inst = inst;
  end

  // OFIFO model: one result per EXEC L0 read, offered as single-cycle valid pulses.
  int          of_pend = 0;
  logic [1:0]  of_prev_inst = 2'b00;
  always @(negedge clk) begin
    if (!reset) begin
      of_pend     = 0;
      ofifo_valid = 1'b0;
    end else begin
      if (l0_rd && (of_prev_inst == 2'b10)) of_pend++;
      if (ofifo_valid) ofifo_valid = 1'b0;
      else if (of_pend > 0) begin
        ofifo_valid = 1'b1;
        of_pend--;
      end
    end
    of_prev_inst = inst;
  end

  task automatic run_job(input string nm, input logic [4:0] ln, input logic [10:0] kb,
                         input logic [10:0] ab, input logic [10:0] pb,
                         input logic rl, input logic ac, input int mode);
    int s_srd, s_wr, s_rd, s_of, s_pw, s_dn, s_kl;
    int act;
    bit fired, got_done;
    logic [10:0] ea;
    s_srd = n_srd; s_wr = n_l0wr; s_rd = n_l0rd; s_of = n_ofrd;
    s_pw = n_pwr; s_dn = n_done; s_kl = n_kl;
    act = 0; fired = 0; got_done = 0;
    exp_relu = rl; exp_acc = ac;
    @(negedge clk); #1;
    len = ln; kbase = kb; abase = ab; pbase = pb; relu_en = rl; acc_en = ac; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0; relu_en = 1'b0; acc_en = 1'b0;
    for (int c = 0; c < 600 && !got_done; c++) begin
      @(negedge clk); #1;
      case (mode)
        1: if (!fired && (n_srd - s_srd == 3)) begin
             l0_full = 1'b1; act = 3; fired = 1;
           end else if (act > 0) begin
             act--;
             if (act == 0) l0_full = 1'b0;
           end
        2: if (!fired && (inst == 2'b10)) begin
             ofifo_full = 1'b1; act = 2; fired = 1;
           end else if (act > 0) begin
             act--;
             if (act == 0) ofifo_full = 1'b0;
           end
        3: if (!fired && (inst == 2'b01)) begin
             start = 1'b1; len = 5'd2; relu_en = ~rl; acc_en = ~ac; fired = 1; act = 1;
           end else if (act > 0) begin
             act = 0; start = 1'b0; len = ln; relu_en = 1'b0; acc_en = 1'b0;
           end
        default: ;
      endcase
      if (n_done != s_dn) got_done = 1;
    end
    chk({nm, "/done_seen"}, 64'(got_done), 64'd1);
    if (mode != 0) chk({nm, "/stim_applied"}, 64'(fired), 64'd1);
    repeat (30) @(negedge clk);
    #1;
    chk({nm, "/sram_rd_cnt"}, 64'(n_srd - s_srd), 64'(8 + int'(ln)));
    chk({nm, "/l0_wr_cnt"},   64'(n_l0wr - s_wr), 64'(8 + int'(ln)));
    chk({nm, "/l0_rd_cnt"},   64'(n_l0rd - s_rd), 64'(8 + int'(ln)));
    chk({nm, "/ofifo_rd_cnt"}, 64'(n_ofrd - s_of), 64'(ln));
    chk({nm, "/psum_wr_cnt"}, 64'(n_pwr - s_pw), 64'(ln));
    chk({nm, "/done_cnt"},    64'(n_done - s_dn), 64'd1);
    chk({nm, "/kload_cycles"}, 64'(n_kl - s_kl), 64'd16);
    for (int i = 0; i < 8; i++) begin
      ea = kb + 11'(i);
      chk({nm, "/kaddr"}, 64'(srd_log[(s_srd + i) & 511]), 64'(ea));
    end
    for (int i = 0; i < int'(ln); i++) begin
      ea = ab + 11'(i);
      chk({nm, "/aaddr"}, 64'(srd_log[(s_srd + 8 + i) & 511]), 64'(ea));
      ea = pb + 11'(i);
      chk({nm, "/paddr"}, 64'(pwr_log[(s_pw + i) & 511]), 64'(ea));
    end
    chk({nm, "/idle_busy"}, 64'({busy, done, relu, accumulate}), 64'd0);
  endtask

  int d0, s0, w0, r0;

  initial begin
    reset = 1'b0; start = 1'b0; len = '0; kbase = '0; abase = '0; pbase = '0;
    relu_en = 1'b0; acc_en = 1'b0; l0_full = 1'b0; l0_ready = 1'b1; ofifo_full = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", 64'({sram_rd, sram_addr, l0_wr, l0_rd, inst, ofifo_rd, psum_wr,
                              psum_addr, accumulate, relu, busy, done}), 64'd0);
    reset = 1'b1;

    // Nominal job
    run_job("nominal", 5'd4, 11'd0, 11'd16, 11'd64, 1'b0, 1'b1, 0);
    // L0 backpressure during WLOAD
    run_job("l0_stall", 5'd4, 11'd0, 11'd16, 11'd64, 1'b0, 1'b0, 1);
    // OFIFO full during EXEC
    run_job("ofifo_full", 5'd4, 11'd100, 11'd200, 11'd300, 1'b0, 1'b0, 2);
    // psum address wrap
    run_job("pwrap", 5'd4, 11'd2040, 11'd8, 11'd2046, 1'b0, 1'b0, 0);
    chk("pwrap/a0", 64'(pwr_log[(n_pwr - 4) & 511]), 64'd2046);
    chk("pwrap/a1", 64'(pwr_log[(n_pwr - 3) & 511]), 64'd2047);
    chk("pwrap/a2", 64'(pwr_log[(n_pwr - 2) & 511]), 64'd0);
    chk("pwrap/a3", 64'(pwr_log[(n_pwr - 1) & 511]), 64'd1);
    // Start while busy ignored; relu=1, acc=0 for the whole job
    run_job("busy_start_cfg", 5'd4, 11'd0, 11'd16, 11'd64, 1'b1, 1'b0, 3);

    // len = 0: done on the second cycle after start, nothing else
    d0 = n_done; s0 = n_srd; w0 = n_l0wr; r0 = n_l0rd;
    exp_relu = 1'b0; exp_acc = 1'b0;
    @(negedge clk); #1;
    len = 5'd0; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    chk("len0/c1_busy", 64'(busy), 64'd1);
    chk("len0/c1_done", 64'(done), 64'd0);
    @(negedge clk); #1;
    chk("len0/c2_done", 64'(done), 64'd1);
    @(negedge clk); #1;
    chk("len0/c3_done", 64'(done), 64'd0);
    repeat (5) @(negedge clk);
    #1;
    chk("len0/activity", 64'((n_srd - s0) + (n_l0wr - w0) + (n_l0rd - r0)), 64'd0);
    chk("len0/done_cnt", 64'(n_done - d0), 64'd1);

    // Reset during EXEC aborts the job
    exp_relu = 1'b1; exp_acc = 1'b1;
    @(negedge clk); #1;
    len = 5'd4; kbase = 11'd0; abase = 11'd16; pbase = 11'd64;
    relu_en = 1'b1; acc_en = 1'b1; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0; relu_en = 1'b0; acc_en = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #1;
      if (inst == 2'b10) break;
    end
    chk("rst/exec_reached", 64'(inst), 64'd2);
    d0 = n_done;
    reset = 1'b0;
    #1;
    chk("rst/outputs_zero", 64'({sram_rd, sram_addr, l0_wr, l0_rd, inst, ofifo_rd, psum_wr,
                                 psum_addr, accumulate, relu, busy, done}), 64'd0);
    @(negedge clk); #1;
    reset = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    chk("rst/no_done", 64'(n_done - d0), 64'd0);
    chk("rst/idle", 64'(busy), 64'd0);
    run_job("after_reset", 5'd3, 11'd32, 11'd48, 11'd500, 1'b0, 1'b1, 0);

    chk("stall/no_rd_when_full", 64'(v_stall), 64'd0);
    chk("stall/addr_hold", 64'(v_hold), 64'd0);
    chk("ofifo_full/no_l0_rd", 64'(v_ofull), 64'd0);
    chk("cfg/relu_acc", 64'(v_cfg), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
